// File: rtl/fifo_ser_pkg.sv
// Shared types and sizing helpers for the FIFO byte serializer.
// Optional word counter on the top is enabled by FIFO_BYTE_SERIALIZER_WORD_COUNT_EN.
package fifo_ser_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      LOAD  = 2'd2,
      SEND  = 2'd3
   } state_e;

   // Bytes per FIFO word.
   function automatic int unsigned nb(input int unsigned data_width);
      return data_width / 8;
   endfunction

   // Byte index width; at least one bit so NB=1 still has a legal vector.
   function automatic int unsigned idx_w(input int unsigned data_width);
      return (data_width / 8 > 1) ? $clog2(data_width / 8) : 1;
   endfunction

endpackage

// File: rtl/byte_select.sv
// Combinational byte mux: picks byte idx_i of word_i in MSB-first or LSB-first order.
module byte_select
   import fifo_ser_pkg::*;
#(
   parameter int unsigned data_width = 16,
   parameter bit          MSB_FIRST  = 1'b1
) (
   input  logic [data_width-1:0]            word_i,
   input  logic [idx_w(data_width)-1:0]     idx_i,
   output logic [7:0]                       byte_c
);

   localparam int unsigned NB_C = nb(data_width);
   localparam int unsigned IW   = idx_w(data_width);

   always_comb begin
      byte_c = 8'h00;
      for (int unsigned i = 0; i < NB_C; i++) begin
         if (idx_i == IW'(i)) begin
            byte_c = MSB_FIRST ? word_i[data_width-1-8*i -: 8] : word_i[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/fifo_byte_serializer.sv
// Read-side FIFO consumer: pops one word, then streams it out byte by byte on valid/ready.
// Define FIFO_BYTE_SERIALIZER_WORD_COUNT_EN to add a saturating popped-word counter.
module fifo_byte_serializer
   import fifo_ser_pkg::*;
#(
   parameter int unsigned data_width = 16,
   parameter bit          MSB_FIRST  = 1'b1
) (
   input  logic                  rclk,
   input  logic                  rrst_n,
   input  logic                  enable,
   input  logic                  rempty,
   input  logic [data_width-1:0] rdata,
   output logic                  rinc,
   output logic [7:0]            byte_data,
   output logic                  byte_valid,
   input  logic                  byte_ready,
`ifdef FIFO_BYTE_SERIALIZER_WORD_COUNT_EN
   input  logic                  count_clr,
   output logic [31:0]           word_count,
`endif
   output logic                  busy
);

   localparam int unsigned   NB_C     = nb(data_width);
   localparam int unsigned   IW       = idx_w(data_width);
   localparam logic [IW-1:0] LAST_IDX = IW'(NB_C - 1);

   state_e                  state_q, state_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [data_width-1:0]   word_q, word_d;
   logic                    rinc_q, rinc_d;
   logic                    valid_q, valid_d;
   logic [7:0]              data_q, data_d;
   logic [7:0]              sel_byte_c;

   // Selector looks at the next-state word/index so byte_data can stay registered.
   byte_select #(
      .data_width (data_width),
      .MSB_FIRST  (MSB_FIRST)
   ) u_byte_select (
      .word_i (word_d),
      .idx_i  (idx_d),
      .byte_c (sel_byte_c)
   );

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         word_q  <= '0;
         rinc_q  <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         rinc_q  <= rinc_d;
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   // rinc is raised from FETCH so its registered copy is high exactly during LOAD.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      word_d  = word_q;
      rinc_d  = 1'b0;
      valid_d = valid_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            if (enable && !rempty) state_d = FETCH;
         end
         FETCH: begin
            rinc_d  = 1'b1;
            state_d = LOAD;
         end
         LOAD: begin
            word_d  = rdata;
            idx_d   = '0;
            valid_d = 1'b1;
            data_d  = sel_byte_c;
            state_d = SEND;
         end
         SEND: begin
            if (valid_q && byte_ready) begin
               if (idx_q == LAST_IDX) begin
                  valid_d = 1'b0;
                  state_d = IDLE;
               end else begin
                  idx_d  = idx_q + 1'b1;
                  data_d = sel_byte_c;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign rinc       = rinc_q;
   assign byte_valid = valid_q;
   assign byte_data  = data_q;
   assign busy       = (state_q != IDLE);

`ifdef FIFO_BYTE_SERIALIZER_WORD_COUNT_EN
   logic [31:0] count_q;

   // Popped-word counter; clear wins over increment, holds at all-ones.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         count_q <= 32'd0;
      end else if (count_clr) begin
         count_q <= 32'd0;
      end else if (rinc_q && (count_q != 32'hFFFF_FFFF)) begin
         count_q <= count_q + 32'd1;
      end
   end

   assign word_count = count_q;
`endif

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Bench: two serializers (MSB-first and LSB-first) share one FIFO model and byte-stream scoreboard.
module tb_fifo_byte_serializer;

   localparam int unsigned DW = 16;
   localparam int unsigned NB = DW / 8;

   logic          rclk;
   logic          rrst_n;
   logic          enable;
   logic          rempty;
   logic [DW-1:0] rdata;
   logic          byte_ready;
   logic          rinc0, rinc1, bv0, bv1, busy0, busy1;
   logic [7:0]    bd0, bd1;
`ifdef FIFO_BYTE_SERIALIZER_WORD_COUNT_EN
   logic          count_clr;
   logic [31:0]   wc0, wc1;
`endif

   int            n_vec = 0;
   int            n_err = 0;

   // FIFO model
   logic [DW-1:0] mem [16];
   int            wr_ptr = 0;
   int            rd_ptr = 0;

   // Scoreboard state
   logic [7:0]    exp0 [$];
   logic [7:0]    exp1 [$];
   int            rinc_cnt0 = 0;
   int            rinc_cnt1 = 0;
   int            acc = 0;
   bit            inflight = 0;
   int            cyc = 0;
   int            last_rinc_cyc = 0;
   int            rinc_gap = 0;
   bit            pv0, pv1, pr;
   logic [7:0]    pd0, pd1;

   fifo_byte_serializer #(.data_width(DW), .MSB_FIRST(1'b1)) u_dut0 (
      .rclk       (rclk),
      .rrst_n     (rrst_n),
      .enable     (enable),
      .rempty     (rempty),
      .rdata      (rdata),
      .rinc       (rinc0),
      .byte_data  (bd0),
      .byte_valid (bv0),
      .byte_ready (byte_ready),
`ifdef FIFO_BYTE_SERIALIZER_WORD_COUNT_EN
      .count_clr  (count_clr),
      .word_count (wc0),
`endif
      .busy       (busy0)
   );

   fifo_byte_serializer #(.data_width(DW), .MSB_FIRST(1'b0)) u_dut1 (
      .rclk       (rclk),
      .rrst_n     (rrst_n),
      .enable     (enable),
      .rempty     (rempty),
      .rdata      (rdata),
      .rinc       (rinc1),
      .byte_data  (bd1),
      .byte_valid (bv1),
      .byte_ready (byte_ready),
`ifdef FIFO_BYTE_SERIALIZER_WORD_COUNT_EN
      .count_clr  (count_clr),
      .word_count (wc1),
`endif
      .busy       (busy1)
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   assign rempty = (wr_ptr == rd_ptr);

   // Registered-read FIFO memory; pops follow the MSB-first instance.
   always @(posedge rclk) begin
      rdata <= mem[rd_ptr % 16];
      if (rinc0) rd_ptr <= rd_ptr + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge rclk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] w);
      mem[wr_ptr % 16] = w;
      wr_ptr++;
      for (int i = 0; i < NB; i++) begin
         exp0.push_back(8'(w >> (8 * (NB - 1 - i))));
         exp1.push_back(8'(w >> (8 * i)));
      end
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (!(wr_ptr == rd_ptr && !busy0 && !busy1 && exp0.size() == 0 && exp1.size() == 0)
             && n < budget) begin
         @(negedge rclk);
         n++;
      end
      chk("drain_in_budget", 32'(n < budget), 32'd1);
   endtask

   task automatic wait_valid(input int budget);
      int n = 0;
      @(negedge rclk);
      while (!bv0 && n < budget) begin
         @(negedge rclk);
         n++;
      end
      chk("valid_in_budget", 32'(bv0), 32'd1);
   endtask

   // Monitor: byte scoreboard, hold-under-backpressure, rinc legality.
   always @(negedge rclk) begin
      cyc++;
      if (!rrst_n) begin
         pv0 = 1'b0;
         pv1 = 1'b0;
         pr  = 1'b0;
      end else begin
         if (rinc0) begin
            rinc_cnt0++;
            chk("rinc_while_empty", 32'(rempty), 32'd0);
            rinc_gap      = cyc - last_rinc_cyc;
            last_rinc_cyc = cyc;
            acc           = 0;
            inflight      = 1'b1;
         end
         if (rinc1) rinc_cnt1++;
         if (pv0 && !pr) begin
            chk("hold_valid0", 32'(bv0), 32'd1);
            chk("hold_data0", 32'(bd0), 32'(pd0));
         end
         if (pv1 && !pr) begin
            chk("hold_valid1", 32'(bv1), 32'd1);
            chk("hold_data1", 32'(bd1), 32'(pd1));
         end
         if (bv0 && byte_ready) begin
            if (exp0.size() == 0) chk("extra_byte0", 32'(bd0), 32'hFFFF_FFFF);
            else                  chk("byte0", 32'(bd0), 32'(exp0.pop_front()));
            acc++;
            if (acc == NB) inflight = 1'b0;
         end
         if (bv1 && byte_ready) begin
            if (exp1.size() == 0) chk("extra_byte1", 32'(bd1), 32'hFFFF_FFFF);
            else                  chk("byte1", 32'(bd1), 32'(exp1.pop_front()));
         end
         pv0 = bv0;
         pv1 = bv1;
         pr  = byte_ready;
         pd0 = bd0;
         pd1 = bd1;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int base0, base1, hold_cnt, n, drop;
      logic [4:0] row [6];
      logic [7:0] rd0 [6];
      logic [7:0] rd1 [6];

      rrst_n     = 1'b1;
      enable     = 1'b0;
      byte_ready = 1'b1;
`ifdef FIFO_BYTE_SERIALIZER_WORD_COUNT_EN
      count_clr  = 1'b0;
`endif
      #2 rrst_n = 1'b0;
      repeat (3) @(posedge rclk);
      #1;
      chk("rst_rinc",  32'(rinc0), 32'd0);
      chk("rst_valid", 32'(bv0),   32'd0);
      chk("rst_data",  32'(bd0),   32'd0);
      chk("rst_busy",  32'(busy0), 32'd0);
      chk("rst_valid1", 32'(bv1),  32'd0);
`ifdef FIFO_BYTE_SERIALIZER_WORD_COUNT_EN
      chk("rst_wcount", wc0, 32'd0);
`endif
      rrst_n = 1'b1;
      enable = 1'b1;
      tick();

      // Single word cycle by cycle: {busy, rinc, valid}
      row[0] = 5'b000; row[1] = 5'b100; row[2] = 5'b110;
      row[3] = 5'b101; row[4] = 5'b101; row[5] = 5'b000;
      rd0[3] = 8'hA5; rd0[4] = 8'h5A;
      rd1[3] = 8'h5A; rd1[4] = 8'hA5;
      push(16'hA55A);
      for (int k = 0; k < 6; k++) begin
         @(negedge rclk);
         chk($sformatf("single_busy_%0d", k),  32'(busy0), 32'(row[k][2]));
         chk($sformatf("single_rinc_%0d", k),  32'(rinc0), 32'(row[k][1]));
         chk($sformatf("single_valid_%0d", k), 32'(bv0),   32'(row[k][0]));
         if (row[k][0]) begin
            chk($sformatf("single_msb_%0d", k), 32'(bd0), 32'(rd0[k]));
            chk($sformatf("single_lsb_%0d", k), 32'(bd1), 32'(rd1[k]));
         end
      end

      // Back-pressure: ready low for 7 cycles on the first byte.
      tick();
      byte_ready = 1'b0;
      push(16'hBEEF);
      wait_valid(20);
      hold_cnt = 0;
      for (int k = 0; k < 7; k++) begin
         if (bv0 && bd0 == 8'hBE && bv1 && bd1 == 8'hEF) hold_cnt++;
         if (k < 6) @(negedge rclk);
      end
      chk("bp_hold_cycles", 32'(hold_cnt), 32'd7);
      tick();
      byte_ready = 1'b1;
      wait_drain(50);

      // Burst of four words, then empty.
      base0 = rinc_cnt0;
      base1 = rinc_cnt1;
      tick();
      for (int i = 1; i <= 4; i++) push(16'(i));
      wait_drain(100);
      chk("burst_rinc0", 32'(rinc_cnt0 - base0), 32'd4);
      chk("burst_rinc1", 32'(rinc_cnt1 - base1), 32'd4);
      chk("burst_word_period", 32'(rinc_gap), 32'(NB + 3));

      // enable dropped in the cycle after LOAD.
      base0 = rinc_cnt0;
      tick();
      push(16'hCAFE);
      push(16'h1234);
      n = 0;
      @(negedge rclk);
      while (!rinc0 && n < 20) begin
         @(negedge rclk);
         n++;
      end
      chk("en_rinc_seen", 32'(rinc0), 32'd1);
      tick();
      enable = 1'b0;
      repeat (10) @(negedge rclk);
      chk("en_rinc_count", 32'(rinc_cnt0 - base0), 32'd1);
      chk("en_busy_low", 32'(busy0), 32'd0);
      chk("en_pending_bytes", 32'(exp0.size()), 32'(NB));
      chk("en_fifo_nonempty", 32'(rempty), 32'd0);
      tick();
      enable = 1'b1;
      wait_drain(50);

      // Async reset mid-SEND.
      tick();
      byte_ready = 1'b0;
      push(16'h7E81);
      wait_valid(20);
      #2 rrst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(bv0),   32'd0);
      chk("arst_rinc",  32'(rinc0), 32'd0);
      chk("arst_busy",  32'(busy0), 32'd0);
      chk("arst_data",  32'(bd0),   32'd0);
      chk("arst_valid1", 32'(bv1),  32'd0);
      drop = inflight ? (NB - acc) : 0;
      for (int i = 0; i < drop; i++) begin
         void'(exp0.pop_front());
         void'(exp1.pop_front());
      end
      inflight = 1'b0;
      acc      = 0;
      repeat (2) @(posedge rclk);
      #1;
`ifdef FIFO_BYTE_SERIALIZER_WORD_COUNT_EN
      chk("arst_wcount", wc0, 32'd0);
`endif
      rrst_n     = 1'b1;
      byte_ready = 1'b1;
      tick();
      push(16'h3C3C);
      push(16'h0FF0);
      push(16'h9001);
      wait_drain(100);
`ifdef FIFO_BYTE_SERIALIZER_WORD_COUNT_EN
      chk("wcount_three", wc0, 32'd3);
      chk("wcount_three1", wc1, 32'd3);
      tick();
      count_clr = 1'b1;
      tick();
      count_clr = 1'b0;
      chk("wcount_clr", wc0, 32'd0);
`endif

      // Randomized traffic with random back-pressure and enable.
      for (int c = 0; c < 400; c++) begin
         tick();
         if (($urandom % 3) == 0 && (wr_ptr - rd_ptr) < 14) push(16'($urandom));
         byte_ready = (($urandom % 4) != 0);
         enable     = (($urandom % 8) != 0);
      end
      tick();
      byte_ready = 1'b1;
      enable     = 1'b1;
      wait_drain(400);
      chk("final_rinc_match", 32'(rinc_cnt1), 32'(rinc_cnt0));
      chk("final_queue0", 32'(exp0.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
